// File: rtl/vga_fill_engine.sv
// Rectangle-fill engine owning VRAM port A; the CPU always wins arbitration, the fill sequencer stalls.
// Optional macro VGA_FILL_VBLANK_SYNC_EN holds each accepted fill until the next vblank rising edge.
module vga_fill_engine #(
    parameter int unsigned HRES = 640,
    parameter int unsigned VRES = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_sel,
    input  logic        cpu_we,
    input  logic [18:0] cpu_addr,
    input  logic [11:0] cpu_wdata,
    output logic [11:0] cpu_rdata,
    input  logic [9:0]  fill_x0,
    input  logic [8:0]  fill_y0,
    input  logic [9:0]  fill_w,
    input  logic [8:0]  fill_h,
    input  logic [11:0] fill_color,
    input  logic        fill_start,
    input  logic        fill_abort,
    input  logic        vblank,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        fill_clip,
    output logic        vram_en,
    output logic        vram_we,
    output logic [18:0] vram_addr,
    output logic [11:0] vram_din,
    input  logic [11:0] vram_dout
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
`ifdef VGA_FILL_VBLANK_SYNC_EN
    localparam logic [1:0] ST_WAITVB = 2'd1;
`endif
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [10:0] HRES_C = 11'(HRES);
    localparam logic [9:0]  VRES_C = 10'(VRES);

    logic [1:0]  state_q, state_d;
    logic [9:0]  col_q, col_d;
    logic [8:0]  row_q, row_d;
    logic [18:0] row_base_q, row_base_d;
    logic [10:0] weff_q, weff_d;
    logic [9:0]  heff_q, heff_d;
    logic [11:0] color_q, color_d;
    logic        clip_q, clip_d;

    logic        fill_wr;
    logic [10:0] x0_ext, w_ext, rem_w;
    logic [9:0]  y0_ext, h_ext, rem_h;
    logic        reject, clip_w, clip_h, col_last, row_last;

    // Constant multiply by HRES as a sum of shifted copies of y0 (one adder per set bit).
    function automatic logic [18:0] mul_hres(input logic [8:0] y);
        logic [18:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 11; i++) begin
            if (((HRES >> i) & 1) != 0) begin
                acc = acc + (19'(y) << i);
            end
        end
        return acc;
    endfunction

`ifdef VGA_FILL_VBLANK_SYNC_EN
    logic vblank_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vblank_q <= 1'b0;
        else        vblank_q <= vblank;
    end
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
`endif

    always_comb begin
        x0_ext   = {1'b0, fill_x0};
        y0_ext   = {1'b0, fill_y0};
        w_ext    = {1'b0, fill_w};
        h_ext    = {1'b0, fill_h};
        rem_w    = HRES_C - x0_ext;
        rem_h    = VRES_C - y0_ext;
        reject   = (fill_w == '0) || (fill_h == '0) || (x0_ext >= HRES_C) || (y0_ext >= VRES_C);
        clip_w   = w_ext > rem_w;
        clip_h   = h_ext > rem_h;
        col_last = (({1'b0, col_q} + 11'd1) == weff_q);
        row_last = (({1'b0, row_q} + 10'd1) == heff_q);
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        weff_d     = weff_q;
        heff_d     = heff_q;
        color_d    = color_q;
        clip_d     = clip_q;
        fill_wr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = mul_hres(fill_y0) + 19'(fill_x0);
                    weff_d     = clip_w ? rem_w : w_ext;
                    heff_d     = clip_h ? rem_h : h_ext;
                    color_d    = fill_color;
                    clip_d     = reject | clip_w | clip_h;
`ifdef VGA_FILL_VBLANK_SYNC_EN
                    state_d    = reject ? ST_DONE : ST_WAITVB;
`else
                    state_d    = reject ? ST_DONE : ST_RUN;
`endif
                end
            end
`ifdef VGA_FILL_VBLANK_SYNC_EN
            ST_WAITVB: begin
                if (fill_abort)               state_d = ST_DONE;
                else if (vblank && !vblank_q) state_d = ST_RUN;
            end
`endif
            ST_RUN: begin
                // Abort suppresses this cycle's write even if it would have been the last one.
                if (fill_abort) begin
                    state_d = ST_DONE;
                end else if (!cpu_sel) begin
                    fill_wr = 1'b1;
                    if (!col_last) begin
                        col_d = col_q + 10'd1;
                    end else if (!row_last) begin
                        col_d      = '0;
                        row_d      = row_q + 9'd1;
                        row_base_d = row_base_q + 19'(HRES);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vram_en   = 1'b0;
        vram_we   = 1'b0;
        vram_addr = '0;
        vram_din  = '0;
        if (cpu_sel) begin
            vram_en   = 1'b1;
            vram_we   = cpu_we;
            vram_addr = cpu_addr;
            vram_din  = cpu_wdata;
        end else if (fill_wr) begin
            vram_en   = 1'b1;
            vram_we   = 1'b1;
            vram_addr = row_base_q + 19'(col_q);
            vram_din  = color_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            weff_q     <= '0;
            heff_q     <= '0;
            color_q    <= '0;
            clip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            weff_q     <= weff_d;
            heff_q     <= heff_d;
            color_q    <= color_d;
            clip_q     <= clip_d;
        end
    end

`ifdef VGA_FILL_VBLANK_SYNC_EN
    assign fill_busy = (state_q == ST_RUN) || (state_q == ST_WAITVB);
`else
    assign fill_busy = (state_q == ST_RUN);
`endif
    assign fill_done = (state_q == ST_DONE);
    assign fill_clip = clip_q;
    assign cpu_rdata = vram_dout;

endmodule

// File: tb/tb_vga_fill_engine.sv
// Directed and randomized bench for vga_fill_engine against a rectangle-list reference model.
module tb_vga_fill_engine;
    localparam int HRES = 640;
    localparam int VRES = 480;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_sel, cpu_we;
    logic [18:0] cpu_addr;
    logic [11:0] cpu_wdata, cpu_rdata;
    logic [9:0]  fill_x0, fill_w;
    logic [8:0]  fill_y0, fill_h;
    logic [11:0] fill_color;
    logic        fill_start, fill_abort, vblank;
    logic        fill_busy, fill_done, fill_clip;
    logic        vram_en, vram_we;
    logic [18:0] vram_addr;
    logic [11:0] vram_din, vram_dout;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    vga_fill_engine #(.HRES(HRES), .VRES(VRES)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .fill_x0(fill_x0), .fill_y0(fill_y0), .fill_w(fill_w), .fill_h(fill_h),
        .fill_color(fill_color), .fill_start(fill_start), .fill_abort(fill_abort),
        .vblank(vblank), .fill_busy(fill_busy), .fill_done(fill_done), .fill_clip(fill_clip),
        .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din),
        .vram_dout(vram_dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 no CPU traffic, 1 CPU write of 0x0AB to address 5 in run cycles 2-3, 2 random CPU traffic.
    // abort_r: run cycle carrying fill_abort (0 = together with the start pulse, <0 = none).
    // start2_r: run cycle carrying a second, to-be-ignored start (<=0 = none).
    task automatic run_fill(input int x0, input int y0, input int w, input int h,
                            input logic [11:0] color, input int mode,
                            input int abort_r, input int start2_r);
        int  weff, heff, total, rem, wait_c, exp_done, done_k, r;
        bit  rejected, clipped, stall;
        int  exp_q[$];
        int  obs_q[$];
        rejected = (w == 0) || (h == 0) || (x0 >= HRES) || (y0 >= VRES);
        weff = rejected ? 0 : ((w < HRES - x0) ? w : HRES - x0);
        heff = rejected ? 0 : ((h < VRES - y0) ? h : VRES - y0);
        clipped = rejected || (weff < w) || (heff < h);
        for (int yy = 0; yy < heff; yy++)
            for (int xx = 0; xx < weff; xx++)
                exp_q.push_back((y0 + yy) * HRES + x0 + xx);
        total = exp_q.size();
        rem = total;
`ifdef VGA_FILL_VBLANK_SYNC_EN
        wait_c = rejected ? 0 : 5;
`else
        wait_c = 0;
`endif
        exp_done = rejected ? 1 : 0;
        done_k = 0;

        @(posedge clk); #1;
        fill_x0 = 10'(x0); fill_y0 = 9'(y0); fill_w = 10'(w); fill_h = 9'(h);
        fill_color = color; fill_start = 1'b1; fill_abort = (abort_r == 0);
`ifdef VGA_FILL_VBLANK_SYNC_EN
        vblank = 1'b1;
`endif
        @(posedge clk); #1;
        fill_start = 1'b0; fill_abort = 1'b0;

        for (int k = 1; k <= 3000; k++) begin
            r = k - wait_c;
`ifdef VGA_FILL_VBLANK_SYNC_EN
            // Already high at start, low in wait cycle 4, rises in wait cycle 5.
            vblank = (k == 4) ? 1'b0 : 1'b1;
`endif
            stall = 1'b0;
            if (r >= 1 && exp_done == 0) begin
                if (abort_r > 0 && r == abort_r) begin
                    fill_abort = 1'b1;
                    while (exp_q.size() > total - rem) void'(exp_q.pop_back());
                    exp_done = k + 1;
                end else begin
                    if (mode == 1)      stall = (r == 2) || (r == 3);
                    else if (mode == 2) stall = ($urandom_range(0, 3) == 0);
                    if (!stall) begin
                        rem--;
                        if (rem == 0) exp_done = k + 1;
                    end
                end
            end
            if (start2_r > 0 && r == start2_r) begin
                fill_start = 1'b1; fill_x0 = '0; fill_y0 = '0;
                fill_w = 10'd5; fill_h = 9'd5; fill_color = 12'h123;
            end
            if (stall) begin
                cpu_sel   = 1'b1;
                cpu_we    = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                cpu_addr  = (mode == 1) ? 19'd5 : 19'($urandom);
                cpu_wdata = (mode == 1) ? 12'h0AB : 12'($urandom);
            end
            vram_dout = 12'($urandom);
            @(negedge clk);
            check("cpu_rdata", 32'(cpu_rdata), 32'(vram_dout));
            if (stall) begin
                check("cpu_en",   32'(vram_en),   32'd1);
                check("cpu_we",   32'(vram_we),   32'(cpu_we));
                check("cpu_addr", 32'(vram_addr), 32'(cpu_addr));
                check("cpu_din",  32'(vram_din),  32'(cpu_wdata));
            end else if (vram_en && vram_we) begin
                obs_q.push_back(int'(vram_addr));
                check("fill_din", 32'(vram_din), 32'(color));
            end
            if (k == 1 && !rejected) check("busy_first", 32'(fill_busy), 32'd1);
            if (fill_done) begin
                done_k = k;
                check("busy_at_done", 32'(fill_busy), 32'd0);
                break;
            end
            @(posedge clk); #1;
            fill_start = 1'b0; fill_abort = 1'b0; cpu_sel = 1'b0;
        end

        check("done_cycle", 32'(done_k), 32'(exp_done));
        check("n_writes", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check("fill_addr", 32'(obs_q[i]), 32'(exp_q[i]));
        check("fill_clip", 32'(fill_clip), 32'(clipped));

        @(posedge clk); #1;
        fill_start = 1'b0; fill_abort = 1'b0; cpu_sel = 1'b0; vblank = 1'b0;
        @(negedge clk);
        check("done_pulse_1cyc", 32'(fill_done), 32'd0);
        check("idle_busy", 32'(fill_busy), 32'd0);
        check("idle_we", 32'(vram_we), 32'd0);
    endtask

    initial begin
        int rx, ry;
        rst_n = 1'b0;
        cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        fill_x0 = '0; fill_y0 = '0; fill_w = '0; fill_h = '0; fill_color = '0;
        fill_start = 1'b0; fill_abort = 1'b0; vblank = 1'b0; vram_dout = '0;
        #12;
        check("rst_busy", 32'(fill_busy), 32'd0);
        check("rst_done", 32'(fill_done), 32'd0);
        check("rst_clip", 32'(fill_clip), 32'd0);
        check("rst_en",   32'(vram_en),   32'd0);
        check("rst_we",   32'(vram_we),   32'd0);
        check("rst_addr", 32'(vram_addr), 32'd0);
        check("rst_din",  32'(vram_din),  32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_fill(10, 20, 4, 3, 12'hF00, 0, -1, -1);
        run_fill(10, 20, 4, 3, 12'hF00, 1, -1, -1);
        run_fill(638, 479, 8, 8, 12'h0F0, 0, -1, -1);
        run_fill(5, 5, 0, 3, 12'h00F, 0, -1, -1);
        run_fill(0, 100, 640, 1, 12'h00F, 0, 3, 2);
        run_fill(1, 1, 2, 2, 12'hABC, 0, 0, -1);
        run_fill(700, 5, 4, 4, 12'h111, 0, -1, -1);
        run_fill(3, 480, 4, 4, 12'h222, 0, -1, -1);

        for (int t = 0; t < 10; t++) begin
            rx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, HRES - 1) : $urandom_range(HRES - 12, HRES + 4);
            ry = ($urandom_range(0, 1) == 0) ? $urandom_range(0, VRES - 1) : $urandom_range(VRES - 6, VRES + 2);
            run_fill(rx, ry, $urandom_range(0, 14), $urandom_range(0, 6), 12'($urandom), 2, -1, -1);
        end

        // Reset in the middle of a fill: back to idle at once, no done pulse afterwards.
        @(posedge clk); #1;
        fill_x0 = '0; fill_y0 = '0; fill_w = 10'd20; fill_h = 9'd1; fill_color = 12'h777;
        fill_start = 1'b1;
        @(posedge clk); #1; fill_start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(fill_busy), 32'd0);
        check("midrst_en",   32'(vram_en),   32'd0);
        check("midrst_done", 32'(fill_done), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("postrst_done", 32'(fill_done), 32'd0);
            check("postrst_we",   32'(vram_we),   32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_fill_engine.md
# vga_fill_engine

Hardware rectangle-fill engine for the VGA controller's VRAM. It owns VRAM port A and arbitrates it between the CPU local bus and an internal fill sequencer. The sequencer writes one 12-bit colour into every pixel of a programmed rectangle. It sits between the VGA register/bus decode and the VRAM write port, on the system clock domain; the pixel-clock read port B is untouched.

## Interface
Parameters:
- HRES, 640, horizontal resolution in pixels (VRAM row pitch)
- VRES, 480, vertical resolution in lines

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_sel  in  1  CPU VRAM access strobe (VRAM address space decoded)
- cpu_we  in  1  CPU write enable
- cpu_addr  in  19  CPU VRAM pixel address
- cpu_wdata  in  12  CPU write pixel
- cpu_rdata  out  12  CPU read pixel (VRAM douta, passed through)
- fill_x0  in  10  rectangle left column
- fill_y0  in  9  rectangle top line
- fill_w  in  10  width in pixels
- fill_h  in  9  height in lines
- fill_color  in  12  fill pixel value {R,G,B}
- fill_start  in  1  one-cycle start pulse
- fill_abort  in  1  one-cycle abort pulse
- vblank  in  1  vertical blank flag from the display timing block
- fill_busy  out  1  fill in progress (includes waiting)
- fill_done  out  1  one-cycle completion/abort pulse
- fill_clip  out  1  sticky: last fill was clipped or rejected; cleared on the next accepted start
- vram_en  out  1  VRAM port A enable
- vram_we  out  1  VRAM port A write enable
- vram_addr  out  19  VRAM port A address
- vram_din  out  12  VRAM port A write data
- vram_dout  in  12  VRAM port A read data

## Operation
- States: IDLE, WAITVB (macro only), RUN, DONE.
- IDLE:
  - fill_start latches x0, y0, w, h and colour, then goes to RUN (or WAITVB).
  - fill_start while busy is ignored.
- Rejection: w==0, h==0, x0>=HRES or y0>=VRES → straight to DONE with no writes; fill_clip=1.
- Clipping:
  - Effective width = min(w, HRES-x0); effective height = min(h, VRES-y0).
  - fill_clip=1 if either was reduced.
- Addressing:
  - Row base starts at y0*HRES+x0, computed once at start by a shift/add of y0, with no general multiplier.
  - Column counter runs 0..weff-1; address = row_base + col.
  - At the end of a row, row_base += HRES and col = 0.
  - After the last row, go to DONE.
- RUN: one pixel write per cycle.
- Arbitration (fixed, CPU has absolute priority):
  - When cpu_sel=1, port A carries the CPU access: vram_en=1, vram_we=cpu_we, vram_addr=cpu_addr, vram_din=cpu_wdata. The fill sequencer stalls that cycle with its counters held.
  - Otherwise port A carries the fill access: vram_en=vram_we=1, vram_addr=fill address, vram_din=colour.
- cpu_rdata = vram_dout at all times.
- Abort: fill_abort in RUN or WAITVB goes to DONE; a write in the same cycle is suppressed. In IDLE, abort is ignored.
- DONE: lasts one cycle; fill_done=1, then IDLE.
- Address width: row_base and address are 19 bits. Max address HRES*VRES-1 = 307199 fits, so no wrap.

## Timing
- Reset values:
  - State IDLE.
  - fill_busy, fill_done, fill_clip, vram_en and vram_we = 0.
  - vram_addr and vram_din = 0.
  - All latched operands = 0.
- fill_start sampled at edge N → fill_busy=1 from N+1.
  - First fill write is at cycle N+1, or at the first cycle after vblank rises (macro).
- With no CPU contention: last write at N+weff*heff; fill_done pulses at N+weff*heff+1, and fill_busy falls in that same cycle.
- Each CPU access cycle during RUN adds exactly one cycle.
- CPU read data is valid one cycle after the cpu_sel read cycle, matching VRAM latency.
- fill_start and fill_abort in the same IDLE cycle: start wins.
- In RUN, abort wins over a completing write.
- Reset asserted mid-fill returns to IDLE immediately, with no done pulse.

## Configuration
- VGA_FILL_VBLANK_SYNC_EN defined:
  - An accepted start enters WAITVB.
  - RUN begins on the first cycle vblank is sampled 0→1, so no writes occur until that rising edge.
  - If vblank is already high at start, the engine still waits for the next rising edge.
- Not defined: WAITVB does not exist, start goes directly to RUN, and vblank is unused.

## Test plan
- x0=10, y0=20, w=4, h=3, colour=12'hF00, no CPU traffic → 12 writes: addresses 12810–12813, 13450–13453, 14090–14093; fill_done at start+13; fill_clip=0.
- Same fill with cpu_sel=1 (write 12'h0AB to address 5) held for the 2nd–3rd fill cycles → CPU write appears on port A in those cycles; fill addresses are unchanged in order; fill_done is delayed by 2 cycles.
- x0=638, y0=479, w=8, h=8 → exactly 2 writes (307198, 307199); fill_clip=1.
- w=0 → no vram_we from the engine; fill_done at start+1; fill_clip=1.
- fill_abort in the 3rd RUN cycle of a 640×1 fill → exactly 2 writes; fill_done the next cycle; a second fill_start during busy is ignored.
- Macro on: start with vblank=1 → no writes until vblank falls then rises; first write the cycle after the rising edge is sampled.
